// File: rtl/fb_pulse_arbiter.sv
// Round-robin arbiter for the shared cochlea feedback line: grants one channel,
// drives a programmable-width pulse on fb_out, then holds a programmable guard gap.
module fb_pulse_arbiter #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_CH-1:0]  req,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] gap_width,
    output logic [N_CH-1:0]  grant,
    output logic             fb_out,
    output logic [N_CH-1:0]  ack,
    output logic             busy
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    state_t             state;
    logic [N_CH-1:0]    pending;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   cur;
    logic [PTR_W-1:0]   win;
    logic               found;
    logic [CNT_W-1:0]   cnt;
    logic [N_CH-1:0]    served;
    logic [CNT_W-1:0]   pulse_load;
    logic [PTR_W-1:0]   ptr_next;

    function automatic logic [N_CH-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // First pass looks at channels at or above ptr; the second pass supplies the wrap-around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && pending[i] && (PTR_W'(i) >= ptr)) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                win   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        served     = (state == PULSE && cnt == '0) ? onehot(cur) : '0;
        pulse_load = (pulse_width == '0) ? '0 : pulse_width - CNT_W'(1);
        ptr_next   = (win == PTR_W'(N_CH - 1)) ? '0 : win + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            ptr     <= '0;
            cur     <= '0;
            cnt     <= '0;
            grant   <= '0;
            fb_out  <= 1'b0;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            ack     <= '0;
            // A request arriving on the clearing edge re-arms the channel.
            pending <= (pending & ~served) | req;
            case (state)
                IDLE: begin
                    if (en && found) begin
                        state  <= PULSE;
                        grant  <= onehot(win);
                        fb_out <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= pulse_load;
                        ptr    <= ptr_next;
                        cur    <= win;
                    end
                end
                PULSE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        fb_out <= 1'b0;
                        grant  <= '0;
                        ack    <= onehot(cur);
                        if (gap_width != '0) begin
                            state <= GAP;
                            cnt   <= gap_width - CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pulse_arbiter.sv
// Directed self-checking bench for fb_pulse_arbiter (N_CH=4, CNT_W=8).
module tb_fb_pulse_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [7:0] pulse_width;
    logic [7:0] gap_width;
    logic [3:0] grant;
    logic       fb_out;
    logic [3:0] ack;
    logic       busy;

    int checks = 0;
    int errors = 0;

    fb_pulse_arbiter #(.N_CH(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .req(req),
        .pulse_width(pulse_width),
        .gap_width(gap_width),
        .grant(grant),
        .fb_out(fb_out),
        .ack(ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0;
        req = '0;
        pulse_width = 8'd1;
        gap_width = 8'd0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (fb_out !== 1'b0) begin errors++; $display("FAIL reset_fb: got %b want 0", fb_out); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        do_reset();
    endtask

    task automatic test_single;
        logic [3:0] eg [0:5];
        logic [3:0] ea [0:5];
        logic       ef [0:5];
        logic       eb [0:5];
        eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        ea = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
        ef = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        en = 1'b1; pulse_width = 8'd3; gap_width = 8'd2; req = 4'b0100;
        tick();
        req = '0;
        checks++; if (fb_out !== 1'b0) begin errors++; $display("FAIL single_latency_fb: got %b want 0", fb_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_latency_busy: got %b want 0", busy); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (grant !== eg[i]) begin errors++; $display("FAIL single_grant[%0d]: got %b want %b", i, grant, eg[i]); end
            checks++; if (ack !== ea[i]) begin errors++; $display("FAIL single_ack[%0d]: got %b want %b", i, ack, ea[i]); end
            checks++; if (fb_out !== ef[i]) begin errors++; $display("FAIL single_fb[%0d]: got %b want %b", i, fb_out, ef[i]); end
            checks++; if (busy !== eb[i]) begin errors++; $display("FAIL single_busy[%0d]: got %b want %b", i, busy, eb[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fb_out !== 1'b0) begin errors++; $display("FAIL single_norepeat[%0d]: got %b want 0", i, fb_out); end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] eg [0:8];
        logic [3:0] ea [0:8];
        logic       eb [0:8];
        eg = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
        ea = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        eb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        en = 1'b1; pulse_width = 8'd1; gap_width = 8'd0; req = 4'b1111;
        tick();
        req = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++; if (grant !== eg[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, eg[i]); end
            checks++; if (ack !== ea[i]) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", i, ack, ea[i]); end
            checks++; if (fb_out !== (eg[i] != 4'b0000)) begin errors++; $display("FAIL rr_fb[%0d]: got %b want %b", i, fb_out, (eg[i] != 4'b0000)); end
            checks++; if (busy !== eb[i]) begin errors++; $display("FAIL rr_busy[%0d]: got %b want %b", i, busy, eb[i]); end
        end
    endtask

    task automatic test_width;
        logic ef [0:4];
        ef = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        en = 1'b1; pulse_width = 8'd0; gap_width = 8'd0; req = 4'b0001;
        tick();
        req = '0;
        tick();
        checks++; if (fb_out !== 1'b1) begin errors++; $display("FAIL pw0_high: got %b want 1", fb_out); end
        tick();
        checks++; if (fb_out !== 1'b0) begin errors++; $display("FAIL pw0_low: got %b want 0", fb_out); end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL pw0_ack: got %b want 0001", ack); end
        tick();
        checks++; if (fb_out !== 1'b0) begin errors++; $display("FAIL pw0_after: got %b want 0", fb_out); end

        pulse_width = 8'd3; req = 4'b0010;
        tick();
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) pulse_width = 8'd10;
            checks++; if (fb_out !== ef[i]) begin errors++; $display("FAIL pw_change_fb[%0d]: got %b want %b", i, fb_out, ef[i]); end
            checks++; if (ack !== ((i == 3) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL pw_change_ack[%0d]: got %b want %b", i, ack, ((i == 3) ? 4'b0010 : 4'b0000)); end
        end
    endtask

    task automatic test_enable;
        logic       ef [0:8];
        logic       eb [0:8];
        logic [3:0] eg [0:9];
        logic [3:0] ea [0:9];
        ef = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        ea = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        do_reset();
        en = 1'b1; pulse_width = 8'd3; gap_width = 8'd2; req = 4'b0001;
        tick();
        req = '0;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL en_first_grant: got %b want 0001", grant); end
        req = 4'b1010; en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            req = '0;
            checks++; if (fb_out !== ef[i]) begin errors++; $display("FAIL en_hold_fb[%0d]: got %b want %b", i, fb_out, ef[i]); end
            checks++; if (busy !== eb[i]) begin errors++; $display("FAIL en_hold_busy[%0d]: got %b want %b", i, busy, eb[i]); end
            checks++; if (ack !== ((i == 2) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL en_hold_ack[%0d]: got %b want %b", i, ack, ((i == 2) ? 4'b0001 : 4'b0000)); end
        end
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (grant !== eg[i]) begin errors++; $display("FAIL en_resume_grant[%0d]: got %b want %b", i, grant, eg[i]); end
            checks++; if (ack !== ea[i]) begin errors++; $display("FAIL en_resume_ack[%0d]: got %b want %b", i, ack, ea[i]); end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        en = 1'b1; pulse_width = 8'd5; gap_width = 8'd0; req = 4'b0100;
        tick();
        req = '0;
        tick();
        tick();
        checks++; if (fb_out !== 1'b1) begin errors++; $display("FAIL areset_pre_fb: got %b want 1", fb_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fb_out !== 1'b0) begin errors++; $display("FAIL areset_fb: got %b want 0", fb_out); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL areset_grant: got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (fb_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_idle[%0d]: got fb=%b busy=%b want 0 0", i, fb_out, busy); end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] eg [0:10];
        logic [3:0] ea [0:10];
        eg = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        ea = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        do_reset();
        en = 1'b1; pulse_width = 8'd2; gap_width = 8'd0; req = 4'b0100;
        tick();
        req = '0;
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL b2b_first_grant: got %b want 0100", grant); end
        req = 4'b1001;
        tick();
        req = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            req = (i == 0) ? 4'b0100 : 4'b0000;
            checks++; if (grant !== eg[i]) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", i, grant, eg[i]); end
            checks++; if (ack !== ea[i]) begin errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, ack, ea[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_width();
        test_enable();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
